mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the 5-stage MIPS pipeline. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from es_stage. It sequences a 2-cycle multiplier and a 32-iteration radix-2 divider, and owns the HI/LO registers. It exports `busy` so ID/EX can interlock MFHI/MFLO and further MDU ops until results commit.

Parameters:
- DIV_ITER, 32, number of divider iterations (one quotient bit per cycle); fixed at the data width.
- XLEN, 32, operand/HI/LO width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  es_stage presents an MDU op
- req_ready  out  1  controller accepts the op this cycle
- req_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved
- req_src1  in  XLEN  rs value (dividend / multiplicand / MTHI/MTLO data)
- req_src2  in  XLEN  rt value (divisor / multiplier)
- flush  in  1  cancel any in-flight op (exception/eret)
- busy  out  1  an op is in flight; HI/LO are not yet final
- done  out  1  one-cycle pulse in the cycle HI/LO are written by MUL/DIV
- hi_rdata  out  XLEN  current HI
- lo_rdata  out  XLEN  current LO

Behaviour:
- Reset values: state=IDLE, HI=0, LO=0, busy=0, done=0, req_ready=0 during reset. req_ready=1 from the first cycle after reset.
- Acceptance: accept = req_valid && req_ready.
  - req_ready = (state==IDLE) && !flush.
  - Reserved op codes are accepted and ignored; there is no state change.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE transitions on accept:
  - MULT/MULTU: latch operands and signedness, go to MUL.
  - DIV/DIVU: latch |src1|, |src2| (plain values for DIVU), quotient sign = s1^s2, remainder sign = s1; clear counter; go to DIV.
  - MTHI/MTLO: write HI/LO at that clock edge; stay in IDLE; busy stays 0.
- MUL (1 cycle):
  - Compute a 64-bit signed or unsigned product from the latched operands.
  - At the end of the cycle: HI=prod[63:32], LO=prod[31:0], done=1 in that cycle, go to IDLE.
  - Accept at edge T gives new HI/LO visible at T+2 (in the cycle after done).
- DIV: one restoring step per cycle. The remainder shifts left by 1, subtracts the divisor if no borrow, and shifts the quotient bit in. The counter runs 0..31; after step 31 go to FIX.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate quotient/remainder per the latched signs).
  - Write LO=quotient, HI=remainder, done=1, go to IDLE.
  - Total: accept at edge T gives HI/LO visible at T+34.
- Divide by zero (either signedness): HI=req_src1 (original value), LO=32'hFFFFFFFF. Sign correction is bypassed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, via natural wrap of the negate.
- busy = (state != IDLE). done is registered as high exactly in the write cycle.
- flush in MUL/DIV/FIX: the op is dropped, HI/LO are unchanged, done=0, and state=IDLE on the next edge. flush has priority over the FIX/MUL write in the same cycle.
- flush in IDLE with req_valid: the op is not accepted, including MTHI/MTLO.
- reset mid-operation: immediate return to the reset values.
- hi_rdata/lo_rdata always reflect the registers. There is no internal forwarding; the consumer stalls on busy.

Optional Feature:
Macro MDU_DIV_ZERO_SHORTCUT_EN.
- Defined: DIV/DIVU with req_src2==0 goes IDLE→FIX directly and commits the divide-by-zero result one cycle after accept (visible at T+2).
- Undefined: a zero divisor runs the full 32 iterations plus FIX; latency matches a normal divide.
- The HI/LO result is identical in both builds.

Decomposition:
- Shared header mycpu.h gets:
  - `MDU_OP_WD (3)
  - op code constants `MDU_OP_MULT … `MDU_OP_MTLO
  - `MDU_ST_* state encodings
  - the bit positions of the MDU fields added to DS_TO_ES_BUS.
- One sub-module, div_iter, holds the remainder/quotient/counter datapath with start/step/last outputs. mdu_ctrl keeps the FSM, multiplier, sign fix and HI/LO.

Test Plan:
1. MULT src1=0xFFFFFFFE(-2), src2=3 → done 1 cycle after accept; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
2. DIV src1=-7(0xFFFFFFF9), src2=2 → busy for 33 cycles, done at the FIX cycle; LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU 100/7 → LO=14, HI=2.
3. DIVU 0x1234/0 → HI=0x00001234, LO=0xFFFFFFFF. Latency is 34 cycles without MDU_DIV_ZERO_SHORTCUT_EN and 2 cycles with it.
4. MTHI 0xDEADBEEF, then next cycle MTLO 0x0BADF00D → both accepted back-to-back with busy=0; hi_rdata/lo_rdata update the following cycle.
5. DIV started, flush asserted at iteration 10 → IDLE next cycle, no done, HI/LO retain their prior values, req_ready=1 the following cycle.
6. req_valid with MULT held while busy → req_ready=0 until the cycle after done; the op is accepted exactly once. reset at DIV iteration 5 → HI=LO=0, busy=0.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared widths, op codes, FSM states and helpers for the MDU controller
package mdu_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER);
  localparam int MDU_OP_WD = 3;

  // Op codes 6 and 7 are reserved: accepted and ignored.
  localparam logic [MDU_OP_WD-1:0] MDU_OP_MULT  = 3'd0;
  localparam logic [MDU_OP_WD-1:0] MDU_OP_MULTU = 3'd1;
  localparam logic [MDU_OP_WD-1:0] MDU_OP_DIV   = 3'd2;
  localparam logic [MDU_OP_WD-1:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [MDU_OP_WD-1:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [MDU_OP_WD-1:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2,
    MDU_ST_FIX  = 2'd3
  } mdu_state_e;

  // Two's-complement negate when neg is set; 0x80000000 wraps onto itself.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - request/response bundle between es_stage and the MDU controller
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [MDU_OP_WD-1:0] req_op;
  logic [XLEN-1:0]      req_src1;
  logic [XLEN-1:0]      req_src2;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [XLEN-1:0]      hi_rdata;
  logic [XLEN-1:0]      lo_rdata;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush,
    input  req_ready, busy, done, hi_rdata, lo_rdata
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush,
    output req_ready, busy, done, hi_rdata, lo_rdata
  );

endinterface

// File: rtl/mdu_ctrl_div_iter.sv
// rtl/mdu_ctrl_div_iter.sv - unsigned restoring divider datapath, one quotient bit per step
module mdu_ctrl_div_iter
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem,
  output logic            o_last
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITER - 1);

  logic [XLEN-1:0]      r_rem;
  logic [XLEN-1:0]      r_quot;
  logic [XLEN-1:0]      r_div;
  logic [DIV_CNT_W-1:0] r_cnt;

  // r_quot starts as the dividend and shifts its MSB into the remainder
  // while quotient bits fill in from the bottom.
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  assign w_rem_sh = {r_rem, r_quot[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  // When w_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_div;

  // Load on start, otherwise perform one restoring step per i_step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_div  <= i_divisor;
      r_cnt  <= '0;
    end else if (i_step) begin
      r_rem  <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      r_quot <= {r_quot[XLEN-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;
  assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU controller: FSM, multiplier, divider sequencing, sign fix, HI/LO (option: MDU_DIV_ZERO_SHORTCUT_EN)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic            r_mul_signed;
  logic            r_q_neg;
  logic            r_r_neg;
  logic            r_dz;

  logic            w_req_ready;
  logic            w_accept;
  logic            w_s1;
  logic            w_s2;
  logic            w_done;
  logic            w_hi_we;
  logic            w_lo_we;
  logic [XLEN-1:0] w_hi_d;
  logic [XLEN-1:0] w_lo_d;
  logic            w_div_start;
  logic            w_div_step;
  logic [XLEN-1:0] w_div_quot;
  logic [XLEN-1:0] w_div_rem;
  logic            w_div_last;

  logic [2*XLEN-1:0] w_mul_a;
  logic [2*XLEN-1:0] w_mul_b;
  logic [2*XLEN-1:0] w_prod;

  assign w_req_ready = (r_state == MDU_ST_IDLE) && !bus.flush && !reset;
  assign w_accept    = bus.req_valid && w_req_ready;

  // Operand signs only matter for signed divide.
  assign w_s1 = (bus.req_op == MDU_OP_DIV) && bus.req_src1[XLEN-1];
  assign w_s2 = (bus.req_op == MDU_OP_DIV) && bus.req_src2[XLEN-1];

  // Extending both operands to 64 bits makes the low 64 bits of the product
  // correct for signed and unsigned alike.
  assign w_mul_a = {{XLEN{r_mul_signed & r_op_a[XLEN-1]}}, r_op_a};
  assign w_mul_b = {{XLEN{r_mul_signed & r_op_b[XLEN-1]}}, r_op_b};
  assign w_prod  = w_mul_a * w_mul_b;

  mdu_ctrl_div_iter u_div_iter (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_div_start),
    .i_step     (w_div_step),
    .i_dividend (abs_val(bus.req_src1, w_s1)),
    .i_divisor  (abs_val(bus.req_src2, w_s2)),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem),
    .o_last     (w_div_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= MDU_ST_IDLE;
    else       r_state <= w_next;
  end

  // Capture operands and sign/zero flags for the op being accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_mul_signed <= 1'b0;
      r_q_neg      <= 1'b0;
      r_r_neg      <= 1'b0;
      r_dz         <= 1'b0;
    end else if (w_accept) begin
      if (bus.req_op == MDU_OP_MULT || bus.req_op == MDU_OP_MULTU) begin
        r_op_a       <= bus.req_src1;
        r_op_b       <= bus.req_src2;
        r_mul_signed <= (bus.req_op == MDU_OP_MULT);
      end else if (bus.req_op == MDU_OP_DIV || bus.req_op == MDU_OP_DIVU) begin
        r_op_a  <= bus.req_src1;
        r_q_neg <= w_s1 ^ w_s2;
        r_r_neg <= w_s1;
        r_dz    <= (bus.req_src2 == '0);
      end
    end
  end

  // Next state, HI/LO write enables and done; flush suppresses any commit.
  always_comb begin
    w_next      = r_state;
    w_done      = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_d      = r_hi;
    w_lo_d      = r_lo;
    w_div_start = 1'b0;
    w_div_step  = 1'b0;
    case (r_state)
      MDU_ST_IDLE: begin
        if (w_accept) begin
          case (bus.req_op)
            MDU_OP_MULT, MDU_OP_MULTU: w_next = MDU_ST_MUL;
            MDU_OP_DIV, MDU_OP_DIVU: begin
              w_div_start = 1'b1;
`ifdef MDU_DIV_ZERO_SHORTCUT_EN
              w_next = (bus.req_src2 == '0) ? MDU_ST_FIX : MDU_ST_DIV;
`else
              w_next = MDU_ST_DIV;
`endif
            end
            MDU_OP_MTHI: begin
              w_hi_we = 1'b1;
              w_hi_d  = bus.req_src1;
            end
            MDU_OP_MTLO: begin
              w_lo_we = 1'b1;
              w_lo_d  = bus.req_src1;
            end
            default: ;
          endcase
        end
      end
      MDU_ST_MUL: begin
        w_next = MDU_ST_IDLE;
        if (!bus.flush) begin
          w_done  = 1'b1;
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = w_prod[2*XLEN-1:XLEN];
          w_lo_d  = w_prod[XLEN-1:0];
        end
      end
      MDU_ST_DIV: begin
        if (bus.flush) begin
          w_next = MDU_ST_IDLE;
        end else begin
          w_div_step = 1'b1;
          if (w_div_last) w_next = MDU_ST_FIX;
        end
      end
      MDU_ST_FIX: begin
        w_next = MDU_ST_IDLE;
        if (!bus.flush) begin
          w_done  = 1'b1;
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          if (r_dz) begin
            w_hi_d = r_op_a;
            w_lo_d = '1;
          end else begin
            w_hi_d = abs_val(w_div_rem, r_r_neg);
            w_lo_d = abs_val(w_div_quot, r_q_neg);
          end
        end
      end
      default: w_next = MDU_ST_IDLE;
    endcase
  end

  // HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.busy      = (r_state != MDU_ST_IDLE);
  assign bus.done      = w_done;
  assign bus.hi_rdata  = r_hi;
  assign bus.lo_rdata  = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_DIV_ZERO_SHORTCUT_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  mdu_ctrl_if bus();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src1  = a;
    bus.req_src2  = b;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (bus.busy === 1'b1) busy_n++;
    end while (bus.done !== 1'b1 && n < limit);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin tests_failed++; $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); end
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h0) begin tests_failed++; $display("FAIL reset_hilo: got %h expected 0", {bus.hi_rdata, bus.lo_rdata}); end
    reset = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_mult;
    int n, b;
    issue(MDU_OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_done(5, n, b);
    tests_run++;
    if (n !== 1) begin tests_failed++; $display("FAIL mult_latency: got %0d expected 1", n); end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hFFFFFFFF_FFFFFFFA) begin tests_failed++; $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFFA", {bus.hi_rdata, bus.lo_rdata}); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL mult_busy_after: got %b expected 0", bus.busy); end
    issue(MDU_OP_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_done(5, n, b);
    tests_run++;
    if (n !== 1) begin tests_failed++; $display("FAIL multu_latency: got %0d expected 1", n); end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h00000002_FFFFFFFA) begin tests_failed++; $display("FAIL multu_result: got %h expected 00000002FFFFFFFA", {bus.hi_rdata, bus.lo_rdata}); end
  endtask

  task automatic test_div;
    int n, b;
    issue(MDU_OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(40, n, b);
    tests_run++;
    if (n !== 33) begin tests_failed++; $display("FAIL div_latency: got %0d expected 33", n); end
    tests_run++;
    if (b !== 33) begin tests_failed++; $display("FAIL div_busy_cycles: got %0d expected 33", b); end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hFFFFFFFF_FFFFFFFD) begin tests_failed++; $display("FAIL div_neg7_2: got %h expected FFFFFFFFFFFFFFFD", {bus.hi_rdata, bus.lo_rdata}); end
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    wait_done(40, n, b);
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL divu_100_7: got %h expected %h", {bus.hi_rdata, bus.lo_rdata}, {32'd2, 32'd14}); end
    issue(MDU_OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait_done(40, n, b);
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h00000001_FFFFFFFD) begin tests_failed++; $display("FAIL div_7_neg2: got %h expected 00000001FFFFFFFD", {bus.hi_rdata, bus.lo_rdata}); end
    issue(MDU_OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(40, n, b);
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h00000000_80000000) begin tests_failed++; $display("FAIL div_overflow: got %h expected 0000000080000000", {bus.hi_rdata, bus.lo_rdata}); end
  endtask

  task automatic test_div_zero;
    int n, b;
    issue(MDU_OP_DIVU, 32'h00001234, 32'd0);
    wait_done(40, n, b);
    tests_run++;
    if (n !== DZ_LAT) begin tests_failed++; $display("FAIL divu_zero_latency: got %0d expected %0d", n, DZ_LAT); end
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h00001234_FFFFFFFF) begin tests_failed++; $display("FAIL divu_zero: got %h expected 00001234FFFFFFFF", {bus.hi_rdata, bus.lo_rdata}); end
    issue(MDU_OP_DIV, 32'hFFFFFFFB, 32'd0);
    wait_done(40, n, b);
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hFFFFFFFB_FFFFFFFF) begin tests_failed++; $display("FAIL div_zero_signed: got %h expected FFFFFFFBFFFFFFFF", {bus.hi_rdata, bus.lo_rdata}); end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = MDU_OP_MTHI; bus.req_src1 = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL mthi_ready: got %b expected 1", bus.req_ready); end
    @(negedge clk);
    bus.req_op = MDU_OP_MTLO; bus.req_src1 = 32'h0BADF00D;
    #1;
    tests_run++;
    if (bus.hi_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL mthi_value: got %h expected DEADBEEF", bus.hi_rdata); end
    tests_run++;
    if ({bus.busy, bus.req_ready} !== 2'b01) begin tests_failed++; $display("FAIL mtlo_busy_ready: got %b expected 01", {bus.busy, bus.req_ready}); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hDEADBEEF_0BADF00D) begin tests_failed++; $display("FAIL mtlo_value: got %h expected DEADBEEF0BADF00D", {bus.hi_rdata, bus.lo_rdata}); end
  endtask

  task automatic test_reserved;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd6; bus.req_src1 = 32'h12345678;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reserved_ready: got %b expected 1", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done} !== 2'b00) begin tests_failed++; $display("FAIL reserved_busy_done: got %b expected 00", {bus.busy, bus.done}); end
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hDEADBEEF_0BADF00D) begin tests_failed++; $display("FAIL reserved_hilo: got %h expected DEADBEEF0BADF00D", {bus.hi_rdata, bus.lo_rdata}); end
  endtask

  task automatic test_flush;
    int pulses;
    issue(MDU_OP_DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    tests_run++;
    if ({bus.done, bus.req_ready} !== 2'b00) begin tests_failed++; $display("FAIL flush_div_done_ready: got %b expected 00", {bus.done, bus.req_ready}); end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.req_ready} !== 2'b01) begin tests_failed++; $display("FAIL flush_div_idle: got %b expected 01", {bus.busy, bus.req_ready}); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL flush_div_no_done: got %0d expected 0", pulses); end
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'hDEADBEEF_0BADF00D) begin tests_failed++; $display("FAIL flush_div_hilo: got %h expected DEADBEEF0BADF00D", {bus.hi_rdata, bus.lo_rdata}); end
    issue(MDU_OP_MULT, 32'd5, 32'd6);
    @(negedge clk);
    bus.flush = 1'b1;
    #1;
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL flush_mul_done: got %b expected 0", bus.done); end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.hi_rdata, bus.lo_rdata} !== {1'b0, 64'hDEADBEEF_0BADF00D}) begin tests_failed++; $display("FAIL flush_mul_hilo: got %h expected 0DEADBEEF0BADF00D", {bus.busy, bus.hi_rdata, bus.lo_rdata}); end
    @(negedge clk);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_op = MDU_OP_MTHI; bus.req_src1 = 32'h11111111;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_ready: got %b expected 0", bus.req_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    #1;
    tests_run++;
    if (bus.hi_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL flush_idle_mthi: got %h expected DEADBEEF", bus.hi_rdata); end
  endtask

  task automatic test_back_to_back;
    int n, done_n, accept_n, accepts, bad;
    logic [63:0] div_snap;
    n = 0; done_n = -1; accept_n = -1; accepts = 0; bad = 0; div_snap = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = MDU_OP_DIVU; bus.req_src1 = 32'd100; bus.req_src2 = 32'd7;
    @(posedge clk);
    #1;
    bus.req_op = MDU_OP_MULT; bus.req_src1 = 32'd5; bus.req_src2 = 32'd6;
    repeat (40) begin
      @(negedge clk); #1;
      n++;
      if (bus.done === 1'b1 && done_n < 0) done_n = n;
      if (n == 34) div_snap = {bus.hi_rdata, bus.lo_rdata};
      if (bus.busy === 1'b1 && bus.req_ready === 1'b1) bad++;
      if (bus.req_valid && bus.req_ready === 1'b1) begin
        accepts++;
        accept_n = n;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end
    tests_run++;
    if (done_n !== 33) begin tests_failed++; $display("FAIL b2b_div_done: got %0d expected 33", done_n); end
    tests_run++;
    if (accept_n !== 34) begin tests_failed++; $display("FAIL b2b_accept_cycle: got %0d expected 34", accept_n); end
    tests_run++;
    if (accepts !== 1) begin tests_failed++; $display("FAIL b2b_accept_count: got %0d expected 1", accepts); end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL b2b_ready_while_busy: got %0d expected 0", bad); end
    tests_run++;
    if (div_snap !== {32'd2, 32'd14}) begin tests_failed++; $display("FAIL b2b_div_result: got %h expected %h", div_snap, {32'd2, 32'd14}); end
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== {32'd0, 32'd30}) begin tests_failed++; $display("FAIL b2b_mult_result: got %h expected %h", {bus.hi_rdata, bus.lo_rdata}, {32'd0, 32'd30}); end
  endtask

  task automatic test_reset_mid;
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({bus.hi_rdata, bus.lo_rdata} !== 64'h0) begin tests_failed++; $display("FAIL reset_mid_hilo: got %h expected 0", {bus.hi_rdata, bus.lo_rdata}); end
    tests_run++;
    if ({bus.busy, bus.done, bus.req_ready} !== 3'b000) begin tests_failed++; $display("FAIL reset_mid_flags: got %b expected 000", {bus.busy, bus.done, bus.req_ready}); end
    reset = 1'b0;
    @(negedge clk); #1;
    tests_run++;
    if ({bus.busy, bus.req_ready} !== 2'b01) begin tests_failed++; $display("FAIL reset_mid_recover: got %b expected 01", {bus.busy, bus.req_ready}); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.flush     = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_reserved();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
